// File: rtl/br_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_pkg
// Description : Shared types and helpers for the branch resolve unit:
//               control-transfer op encoding, op classification and the
//               reset value of the branch history counters.
// Revision    : 1.0 - initial release
// ============================================================================
package br_pkg;

    // Codes 0-5 keep the values of the older 3-bit encoding, zero-extended,
    // so legacy decoders can drive this unit with a padded op field.
    typedef enum logic [3:0] {
        NOP  = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BLT  = 4'd3,
        BGE  = 4'd4,
        JAL  = 4'd5,
        BLTU = 4'd6,
        BGEU = 4'd7,
        JALR = 4'd8
    } branch_op_e;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] BHT_INIT = 2'b01;

    // Conditional branches: the ones that train the BHT and are counted.
    function automatic logic is_cond(input logic [3:0] op);
        logic r;
        case (op)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Unconditional jumps: always taken, never train the BHT.
    function automatic logic is_jump(input logic [3:0] op);
        return (op == JAL) || (op == JALR);
    endfunction

    // Saturating 2-bit counter step.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end else begin
            r = (cnt == 2'b00) ? cnt : cnt - 2'b01;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_bht.sv
`default_nettype none
// ============================================================================
// Module      : br_bht
// Description : Branch history table of 2-bit saturating counters with one
//               combinational read port (prediction = counter MSB) and one
//               synchronous saturating update port.
// Revision    : 1.0 - initial release
// ============================================================================
module br_bht
    import br_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] r_cnt [ENTRIES];
    logic [1:0] w_next;

    // Next value of the counter being trained.
    always_comb begin
        w_next = sat_step(r_cnt[wr_idx], wr_taken);
    end

    // Counter array: all entries return to weakly not-taken on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            r_cnt[wr_idx] <= w_next;
        end
    end

    // Read sees the registered array, so a same-cycle update of the same
    // entry is not visible until the following cycle.
    assign rd_taken = r_cnt[rd_idx][1];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves RV32I control-transfer ops (conditional branches,
//               JAL, JALR), computes redirect target and link address,
//               flags mispredictions against the fetch prediction, trains
//               a 2-bit BHT and keeps branch/mispredict counters. Results
//               are held in a one-entry registered valid/ready stage.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  d1,
    input  logic [XLEN-1:0]  d2,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             take_branch,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  link,
    output logic             mispredict,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Registered result stage and counters.
    logic             r_out_valid;
    logic             r_take;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_link;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // Combinational resolution of the presented op.
    logic             w_accept;
    logic             w_cond;
    logic             w_jump;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_take;
    logic [XLEN-1:0]  w_pc_sum;
    logic [XLEN-1:0]  w_reg_sum;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_link;
    logic             w_mispredict;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_lookup_idx;
    logic             w_unused_lookup;

    // A held result blocks new work only while the consumer stalls it.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_cond = is_cond(op);
    assign w_jump = is_jump(op);

    // Comparator and adder datapath; sums wrap modulo 2^XLEN.
    always_comb begin
        w_eq      = (d1 == d2);
        w_lt      = ($signed(d1) < $signed(d2));
        w_ltu     = (d1 < d2);
        w_pc_sum  = pc + imm;
        w_reg_sum = d1 + imm;
        w_link    = pc + XLEN'(4);
    end

    // Taken decision; unknown op codes fall through as NOP.
    always_comb begin
        w_take = 1'b0;
        case (op)
            BEQ:       w_take = w_eq;
            BNE:       w_take = !w_eq;
            BLT:       w_take = w_lt;
            BGE:       w_take = !w_lt;
            BLTU:      w_take = w_ltu;
            BGEU:      w_take = !w_ltu;
            JAL, JALR: w_take = 1'b1;
            default:   w_take = 1'b0;
        endcase
    end

    // Redirect target and misprediction flag. JALR clears bit 0 of the
    // register-relative sum; everything else is PC-relative.
    always_comb begin
        w_target     = w_pc_sum;
        w_mispredict = 1'b0;
        if (op == JALR) begin
            w_target = {w_reg_sum[XLEN-1:1], 1'b0};
        end
        if (w_cond) begin
            w_mispredict = (w_take != pred_taken_in);
        end else if (w_jump) begin
            w_mispredict = !pred_taken_in;
        end
    end

    // One-entry output stage: load on accept, drain when consumed, and
    // hold everything stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_take       <= 1'b0;
            r_target     <= '0;
            r_link       <= '0;
            r_mispredict <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_take       <= w_take;
            r_target     <= w_target;
            r_link       <= w_link;
            r_mispredict <= w_mispredict;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Performance counters, advanced only by accepted ops; wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_accept) begin
            if (w_cond) begin
                r_branch_count <= r_branch_count + CNT_W'(1);
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    // BHT is indexed by word address bits, skipping the byte offset.
    assign w_upd_idx    = pc[IDX_W+1:2];
    assign w_lookup_idx = lookup_pc[IDX_W+1:2];

    // Bits of the lookup PC outside the index are irrelevant to prediction.
    assign w_unused_lookup = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    br_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (w_lookup_idx),
        .rd_taken (lookup_taken),
        .wr_en    (w_accept && w_cond),
        .wr_idx   (w_upd_idx),
        .wr_taken (w_take)
    );

    assign out_valid        = r_out_valid;
    assign take_branch      = r_take;
    assign target           = r_target;
    assign link             = r_link;
    assign mispredict       = r_mispredict;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
    import br_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        pred_taken_in;
    logic        out_valid;
    logic        out_ready;
    logic        take_branch;
    logic [31:0] target;
    logic [31:0] link;
    logic        mispredict;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int tests;
    int fails;

    branch_resolve_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .CNT_W       (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op               (op),
        .pc               (pc),
        .d1               (d1),
        .d2               (d2),
        .imm              (imm),
        .pred_taken_in    (pred_taken_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .take_branch      (take_branch),
        .target           (target),
        .link             (link),
        .mispredict       (mispredict),
        .lookup_pc        (lookup_pc),
        .lookup_taken     (lookup_taken),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i, input logic pr);
        in_valid      = 1'b1;
        op            = o;
        pc            = p;
        d1            = a;
        d2            = b;
        imm           = i;
        pred_taken_in = pr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic t, input logic [31:0] tg,
                                input logic [31:0] lk, input logic m);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".take"}, 64'(take_branch), 64'(t));
        check({tag, ".target"}, 64'(target), 64'(tg));
        check({tag, ".link"}, 64'(link), 64'(lk));
        check({tag, ".misp"}, 64'(mispredict), 64'(m));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        lookup_pc = 32'h0;
        in_valid = 1'b0;
        drive(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        in_valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.take", 64'(take_branch), 64'd0);
        check("rst.target", 64'(target), 64'd0);
        check("rst.link", 64'(link), 64'd0);
        check("rst.misp", 64'(mispredict), 64'd0);
        check("rst.bcnt", 64'(branch_count), 64'd0);
        check("rst.mcnt", 64'(mispredict_count), 64'd0);
        check("rst.lookup", 64'(lookup_taken), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // JALR from a fresh state: (0x1001+4)=0x1005 -> 0x1004
        drive(JALR, 32'h100, 32'h1001, 32'h0, 32'h4, 1'b0);
        step();
        check_result("jalr", 1'b1, 32'h1004, 32'h104, 1'b1);
        check("jalr.mcnt", 64'(mispredict_count), 64'd1);
        check("jalr.bcnt", 64'(branch_count), 64'd0);

        // BLT vs BLTU: -1 < 1 signed, 0xFFFFFFFF > 1 unsigned (BHT index 0)
        drive(BLT, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0);
        step();
        check_result("blt", 1'b1, 32'h120, 32'h104, 1'b1);
        drive(BLTU, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0);
        step();
        check_result("bltu", 1'b0, 32'h120, 32'h104, 1'b0);
        check("bltu.bcnt", 64'(branch_count), 64'd2);
        check("bltu.mcnt", 64'(mispredict_count), 64'd2);
        check("bltu.lookup0", 64'(lookup_taken), 64'd0);

        // Backpressure: BEQ(5,5) at index 1, then stall with BNE waiting
        drive(BEQ, 32'h204, 32'h5, 32'h5, 32'h8, 1'b1);
        step();
        check_result("beq", 1'b1, 32'h20C, 32'h208, 1'b0);
        drive(BNE, 32'h308, 32'h1, 32'h2, 32'h10, 1'b1);
        out_ready = 1'b0;
        #1;
        check("bp.in_ready_now", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check_result("bp.hold", 1'b1, 32'h20C, 32'h208, 1'b0);
        end
        check("bp.bcnt", 64'(branch_count), 64'd3);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_rel", 64'(in_ready), 64'd1);
        step();
        check_result("bne", 1'b1, 32'h318, 32'h30C, 1'b0);
        check("bne.bcnt", 64'(branch_count), 64'd4);
        check("bne.mcnt", 64'(mispredict_count), 64'd2);

        // BHT saturation at pc 0x40: 1->2->3->3->3 then 2->1
        lookup_pc = 32'h40;
        #1;
        check("sat.init", 64'(lookup_taken), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(BEQ, 32'h40, 32'h7, 32'h7, 32'h4, 1'b0);
            step();
            check("sat.taken", 64'(lookup_taken), 64'd1);
        end
        drive(BEQ, 32'h40, 32'h7, 32'h8, 32'h4, 1'b0);
        step();
        check("sat.nt1", 64'(lookup_taken), 64'd1);
        drive(BEQ, 32'h40, 32'h7, 32'h8, 32'h4, 1'b0);
        step();
        check("sat.nt2", 64'(lookup_taken), 64'd0);
        check("sat.bcnt", 64'(branch_count), 64'd10);
        check("sat.mcnt", 64'(mispredict_count), 64'd6);

        // Same-cycle update/lookup at index 0 (counter 1)
        lookup_pc = 32'h0;
        drive(BEQ, 32'h0, 32'h3, 32'h3, 32'h4, 1'b1);
        @(negedge clk);
        check("same.before", 64'(lookup_taken), 64'd0);
        step();
        check("same.after", 64'(lookup_taken), 64'd1);
        check_result("same", 1'b1, 32'h4, 32'h4, 1'b0);

        // Undefined op code acts as NOP
        drive(4'hF, 32'h10, 32'h1, 32'h1, 32'h10, 1'b1);
        step();
        check_result("undef", 1'b0, 32'h20, 32'h14, 1'b0);
        check("undef.bcnt", 64'(branch_count), 64'd11);
        check("undef.mcnt", 64'(mispredict_count), 64'd6);

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.target", 64'(target), 64'd0);
        check("arst.bcnt", 64'(branch_count), 64'd0);
        check("arst.mcnt", 64'(mispredict_count), 64'd0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            check("arst.lookup", 64'(lookup_taken), 64'd0);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // First accept right after reset release; link/target wrap
        drive(JAL, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b1);
        step();
        check_result("jal", 1'b1, 32'h4, 32'h0, 1'b0);
        in_valid = 1'b0;
        step();
        check("drain.out_valid", 64'(out_valid), 64'd0);
        check("drain.bcnt", 64'(branch_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
